// File: rtl/v810_dmem_resp_if.sv
// Initiator/responder bus of the V810 data-memory responder.
// Handshake: the initiator drives MRQn low and holds MRQn, RW, DA, BEn and DD_I stable
// until it samples READYn=0; READYn is low for exactly one cycle per completed access,
// and read data is valid on DD_O in that cycle and held until the next read completes.
interface v810_dmem_resp_if;
  logic        MRQn;
  logic        RW;
  logic [31:0] DA;
  logic [3:0]  BEn;
  logic [31:0] DD_I;
  logic [31:0] DD_O;
  logic        READYn;

  modport master (output MRQn, RW, DA, BEn, DD_I, input DD_O, READYn);
  modport slave  (input MRQn, RW, DA, BEn, DD_I, output DD_O, READYn);
endinterface

// File: rtl/v810_dmem_resp.sv
// Wait-stated single-port data memory responder for a V810-style initiator.
// Optional feature macro: DMEM_WAIT_STATES_EN (wait states honoured when defined).
module v810_dmem_resp #(
  parameter int AW   = 10,
  parameter int WAIT = 2
) (
  input  logic                   CLK,
  input  logic                   RESn,
  input  logic                   CE,
  v810_dmem_resp_if.slave        bus,
  output logic [1:0]             dbg_state
);

`ifdef DMEM_WAIT_STATES_EN
  typedef enum logic [1:0] {S_IDLE = 2'd0, S_WAIT = 2'd1, S_DONE = 2'd2} state_t;
  localparam logic [3:0] WAIT_LOAD = (WAIT > 0) ? 4'(WAIT - 1) : 4'd0;
  logic [3:0] cnt_q, cnt_d;
`else
  typedef enum logic [1:0] {S_IDLE = 2'd0, S_DONE = 2'd2} state_t;
`endif

  state_t      state_q, state_d;
  logic        do_access;
  logic        ready_n_q;
  logic [31:0] dd_o_q;
  logic [31:0] mem [2**AW];
  logic [AW-1:0] idx;

  assign idx = bus.DA[AW+1:2];

  // Address bits outside the word index alias by design; WAIT is ignored without the macro.
  logic unused_bits;
  assign unused_bits = ^{bus.DA[31:AW+2], bus.DA[1:0], 4'(WAIT)};

  always_comb begin
    state_d   = state_q;
    do_access = 1'b0;
`ifdef DMEM_WAIT_STATES_EN
    cnt_d     = cnt_q;
`endif
    case (state_q)
      S_IDLE: begin
        if (!bus.MRQn) begin
`ifdef DMEM_WAIT_STATES_EN
          if (WAIT > 0) begin
            state_d = S_WAIT;
            cnt_d   = WAIT_LOAD;
          end else begin
            state_d   = S_DONE;
            do_access = 1'b1;
          end
`else
          state_d   = S_DONE;
          do_access = 1'b1;
`endif
        end
      end
`ifdef DMEM_WAIT_STATES_EN
      S_WAIT: begin
        // A withdrawn request abandons the access before anything is committed.
        if (bus.MRQn) begin
          state_d = S_IDLE;
        end else if (cnt_q == 4'd0) begin
          state_d   = S_DONE;
          do_access = 1'b1;
        end else begin
          cnt_d = cnt_q - 4'd1;
        end
      end
`endif
      S_DONE:  state_d = S_IDLE;
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge CLK) begin
    if (!RESn) begin
      state_q   <= S_IDLE;
      ready_n_q <= 1'b1;
      dd_o_q    <= 32'd0;
`ifdef DMEM_WAIT_STATES_EN
      cnt_q     <= 4'd0;
`endif
    end else if (CE) begin
      state_q   <= state_d;
      ready_n_q <= (state_d != S_DONE);
`ifdef DMEM_WAIT_STATES_EN
      cnt_q     <= cnt_d;
`endif
      if (do_access && bus.RW) begin
        dd_o_q <= mem[idx];
      end
    end
  end

  // Memory has no reset; reset only suppresses a write landing on the same edge.
  always_ff @(posedge CLK) begin
    if (RESn && CE && do_access && !bus.RW) begin
      for (int b = 0; b < 4; b++) begin
        if (!bus.BEn[b]) begin
          mem[idx][8*b +: 8] <= bus.DD_I[8*b +: 8];
        end
      end
    end
  end

  assign bus.DD_O   = dd_o_q;
  assign bus.READYn = ready_n_q;
  assign dbg_state  = state_q;

endmodule

// File: tb/tb_v810_dmem_resp.sv
// Self-checking bench for v810_dmem_resp: directed steps plus random traffic
// checked against a word-array memory model and a read-data expectation queue.
module tb_v810_dmem_resp;
  localparam int AW     = 4;
  localparam int DEPTH  = 1 << AW;
  localparam int TB_WAIT = 3;
`ifdef DMEM_WAIT_STATES_EN
  localparam int EFF_WAIT = TB_WAIT;
`else
  localparam int EFF_WAIT = 0;
`endif
  localparam int PRE = (EFF_WAIT > 0) ? 1 : 0;

  logic clk = 1'b0;
  logic resn;
  logic ce;
  logic [1:0] dbg_state;

  v810_dmem_resp_if bus ();

  v810_dmem_resp #(.AW(AW), .WAIT(TB_WAIT)) dut (
    .CLK       (clk),
    .RESn      (resn),
    .CE        (ce),
    .bus       (bus),
    .dbg_state (dbg_state)
  );

  // Clock and watchdog
  always #5 clk = ~clk;

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish, observed timeout required finish");
    $fatal(1, "watchdog expired");
  end

  // Scoreboard state
  logic [31:0] model_mem [DEPTH];
  logic [31:0] exp_q [$];
  int n_checks = 0;
  int n_errors = 0;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    assert (obs === exp) else begin
      n_errors++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Driver tasks
  task automatic drive(input logic rw, input logic [31:0] da, input logic [3:0] ben,
                       input logic [31:0] di);
    bus.RW   = rw;
    bus.DA   = da;
    bus.BEn  = ben;
    bus.DD_I = di;
    bus.MRQn = 1'b0;
  endtask

  task automatic model_apply(input logic rw, input logic [31:0] da, input logic [3:0] ben,
                             input logic [31:0] di);
    int i;
    i = int'((da >> 2) % DEPTH);
    if (rw) begin
      exp_q.push_back(model_mem[i]);
    end else begin
      for (int b = 0; b < 4; b++) begin
        if (!ben[b]) model_mem[i][8*b +: 8] = di[8*b +: 8];
      end
    end
  endtask

  task automatic wait_ready(output int edges);
    edges = 0;
    do begin
      tick();
      edges++;
    end while (bus.READYn !== 1'b0 && edges < 64);
  endtask

  task automatic check_read(input string tag);
    logic [31:0] e;
    if (exp_q.size() == 0) begin
      e = 32'hxxxx_xxxx;
      $error("FAIL %s_q: observed empty queue required entry", tag);
      n_errors++;
      n_checks++;
    end else begin
      e = exp_q.pop_front();
      chk({tag, "_data"}, bus.DD_O, e);
    end
  endtask

  task automatic access(input string tag, input logic rw, input logic [31:0] da,
                        input logic [3:0] ben, input logic [31:0] di);
    int edges;
    drive(rw, da, ben, di);
    model_apply(rw, da, ben, di);
    wait_ready(edges);
    chk({tag, "_lat"}, 32'(edges), 32'(EFF_WAIT + 1));
    if (rw) check_read(tag);
    bus.MRQn = 1'b1;
    tick();
    chk({tag, "_rdy_hi"}, {31'd0, bus.READYn}, 32'd1);
  endtask

  initial begin
    int edges;
    int low_seen;
    logic rw;
    logic [31:0] da;

    bus.MRQn = 1'b1;
    bus.RW   = 1'b1;
    bus.DA   = 32'd0;
    bus.BEn  = 4'hF;
    bus.DD_I = 32'd0;

    // Reset with CE low must still initialise the outputs.
    resn = 1'b0;
    ce   = 1'b0;
    repeat (3) tick();
    chk("reset_readyn", {31'd0, bus.READYn}, 32'd1);
    chk("reset_ddo", bus.DD_O, 32'd0);
    ce   = 1'b1;
    tick();
    resn = 1'b1;
    tick();
    chk("idle_readyn", {31'd0, bus.READYn}, 32'd1);

    // Full-word write then read back.
    access("wr_deadbeef", 1'b0, 32'h10, 4'h0, 32'hDEADBEEF);
    access("rd_deadbeef", 1'b1, 32'h10, 4'h0, 32'h0);

    // Byte-enable merge.
    access("wr_base", 1'b0, 32'h10, 4'h0, 32'h11223344);
    access("wr_merge", 1'b0, 32'h10, 4'b1010, 32'hAABBCCDD);
    access("rd_merge", 1'b1, 32'h10, 4'hF, 32'h0);
    chk("merge_value", model_mem[4], 32'h11BB33DD);

    // All bytes disabled: handshake completes, memory untouched.
    access("wr_noben", 1'b0, 32'h10, 4'hF, 32'h01234567);
    access("rd_noben", 1'b1, 32'h10, 4'h0, 32'h0);

    // Aliased address: low two bits and bits above the index ignored.
    access("rd_alias", 1'b1, 32'hFFFF_FF13, 4'h5, 32'h0);

    // DD_O holds through a write.
    access("wr_hold", 1'b0, 32'h24, 4'h0, 32'hCAFE0009);
    chk("ddo_hold", bus.DD_O, 32'h11BB33DD);

`ifdef DMEM_WAIT_STATES_EN
    // Request withdrawn one cycle into WAIT: no completion, no write.
    drive(1'b0, 32'h10, 4'h0, 32'h55555555);
    tick();
    tick();
    bus.MRQn = 1'b1;
    low_seen = 0;
    repeat (8) begin
      tick();
      if (bus.READYn !== 1'b1) low_seen++;
    end
    chk("abort_no_ready", 32'(low_seen), 32'd0);
    access("rd_after_abort", 1'b1, 32'h10, 4'h0, 32'h0);
`endif

    // Back-to-back reads with MRQn held low.
    drive(1'b1, 32'h10, 4'h0, 32'h0);
    model_apply(1'b1, 32'h10, 4'h0, 32'h0);
    model_apply(1'b1, 32'h10, 4'h0, 32'h0);
    wait_ready(edges);
    chk("b2b_lat1", 32'(edges), 32'(EFF_WAIT + 1));
    check_read("b2b_1");
    wait_ready(edges);
    chk("b2b_lat2", 32'(edges), 32'(EFF_WAIT + 2));
    check_read("b2b_2");
    bus.MRQn = 1'b1;
    tick();
    chk("b2b_rdy_hi", {31'd0, bus.READYn}, 32'd1);

    // CE low for three edges while a read is in flight.
    drive(1'b1, 32'h24, 4'h0, 32'h0);
    model_apply(1'b1, 32'h24, 4'h0, 32'h0);
    repeat (PRE) tick();
    ce = 1'b0;
    for (int k = 0; k < 3; k++) begin
      tick();
      chk($sformatf("ce_frozen_%0d", k), {31'd0, bus.READYn}, 32'd1);
    end
    chk("ce_ddo_frozen", bus.DD_O, 32'h11BB33DD);
    ce = 1'b1;
    wait_ready(edges);
    chk("ce_lat", 32'(edges + PRE + 3), 32'(EFF_WAIT + 4));
    check_read("ce_rd");
    bus.MRQn = 1'b1;
    tick();

    // Reset on the DONE-entry edge of a write to word 8.
    access("wr_pre8", 1'b0, 32'h20, 4'h0, 32'h5A5A0808);
    access("rd_pre8", 1'b1, 32'h20, 4'h0, 32'h0);
    drive(1'b0, 32'h20, 4'h0, 32'hBAD0BAD0);
    repeat (EFF_WAIT) tick();
    resn = 1'b0;
    tick();
    chk("rst_done_readyn", {31'd0, bus.READYn}, 32'd1);
    chk("rst_done_ddo", bus.DD_O, 32'd0);
    bus.MRQn = 1'b1;
    resn = 1'b1;
    tick();
    access("rd_post_rst8", 1'b1, 32'h20, 4'h0, 32'h0);
    access("rd_post_rst4", 1'b1, 32'h10, 4'h0, 32'h0);

    // Fill every word, then random traffic.
    for (int w = 0; w < DEPTH; w++) begin
      access($sformatf("fill_%0d", w), 1'b0, 32'(w << 2), 4'h0, $urandom());
    end
    for (int n = 0; n < 40; n++) begin
      rw = 1'($urandom_range(0, 1));
      da = ($urandom() & 32'hFFFF_FFC3) | 32'($urandom_range(0, DEPTH - 1) << 2);
      access($sformatf("rnd_%0d", n), rw, da, 4'($urandom_range(0, 15)), $urandom());
    end

    chk("exp_q_drained", 32'(exp_q.size()), 32'd0);

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end
endmodule

// File: doc/v810_dmem_resp.md
V810_DMEM_RESP -- requirements
Module: v810_dmem_resp

Interface
REQ-001 SHALL have parameter AW, default 10, word-address width; memory holds 2**AW 32-bit words.
REQ-002 SHALL have parameter WAIT, default 2, wait states per access, range 0..15.
REQ-003 SHALL have CLK  input  1  sole clock; all state updates on rising edge.
REQ-004 SHALL have RESn  input  1  reset, synchronous, active-low.
REQ-005 SHALL have CE  input  1  clock enable; CE=0 freezes all state and memory.
REQ-006 SHALL have MRQn  input  1  initiator memory request, active-low.
REQ-007 SHALL have RW  input  1  1=read, 0=write.
REQ-008 SHALL have DA  input  32  byte address; word index DA[AW+1:2], other bits ignored (aliasing).
REQ-009 SHALL have BEn  input  4  byte enables, active-low, BEn[n] for DD_I[8n+7:8n].
REQ-010 SHALL have DD_I  input  32  write data from initiator.
REQ-011 SHALL have DD_O  output  32  read data to initiator, registered.
REQ-012 SHALL have READYn  output  1  access-complete strobe, active-low, registered.

Function
REQ-013 SHALL implement states IDLE, WAIT, DONE; all transitions only on rising CLK with CE=1.
REQ-014 IDLE: MRQn=0 -> WAIT (load counter with WAIT-1) if WAIT>0, else -> DONE; MRQn=1 -> stay.
REQ-015 WAIT: counter decrements each cycle; at counter=0 -> DONE.
REQ-016 WAIT: MRQn=1 sampled -> abort to IDLE; no write, no READYn pulse, DD_O unchanged.
REQ-017 Transition into DONE: read loads DD_O with full word mem[DA[AW+1:2]]; write updates each byte with BEn[n]=0 from DD_I.
REQ-018 Read ignores BEn; all 32 bits of DD_O driven with stored word.
REQ-019 Write with BEn=4'hF SHALL complete handshake normally with memory unchanged.
REQ-020 READYn SHALL be 0 exactly while in DONE (one cycle), else 1.
REQ-021 DONE -> IDLE unconditionally; a still-low MRQn begins a new access from IDLE on the next edge (min 2 cycles/access at WAIT=0).
REQ-022 Initiator holds MRQn, RW, DA, BEn, DD_I stable from request until READYn=0 is sampled; responder samples them at the DONE-entry edge.
REQ-023 DD_O SHALL hold its value outside read DONE entries.
REQ-024 DA[1:0] SHALL be ignored; no misalignment fault.
REQ-025 Latency request-sample edge to READYn=0: WAIT+1 edges (enabled CE cycles).

Reset
REQ-026 RESn=0 at a rising edge SHALL force IDLE, READYn=1, DD_O=0, counter=0, regardless of CE.
REQ-027 Reset SHALL take priority over a pending DONE entry; no write occurs on that edge.
REQ-028 Reset SHALL NOT clear memory contents.

Configuration
REQ-029 Macro DMEM_WAIT_STATES_EN defined: WAIT honoured per REQ-014/015.
REQ-030 Macro DMEM_WAIT_STATES_EN undefined: WAIT state and counter absent; IDLE -> DONE directly; WAIT parameter ignored.

Verification
REQ-031 WAIT=0: write DA=0x10, DD_I=0xDEADBEEF, BEn=0 -> READYn=0 one edge after request; read DA=0x10 -> DD_O=0xDEADBEEF with READYn=0.
REQ-032 WAIT=2: read request at edge N -> READYn=0 after edge N+3 only, high otherwise; same with macro undefined -> after edge N+1.
REQ-033 mem[4]=0x11223344, write DA=0x10, DD_I=0xAABBCCDD, BEn=4'b1010 -> mem[4]=0x11BB33DD.
REQ-034 WAIT=3: MRQn raised in WAIT after 1 cycle during write -> back to IDLE, READYn never 0, memory unchanged.
REQ-035 RESn=0 on DONE-entry edge of a write to DA=0x20 -> mem[8] unchanged, READYn=1, DD_O=0; prior memory contents preserved.
REQ-036 CE=0 for 3 cycles mid-WAIT -> state/counter frozen; READYn asserts 3 edges later than with CE=1.
